// File: rtl/duty_ramp.sv
// duty_ramp: slew-rate limiter feeding the motor PWM duty_cycle input.
// Accepts target duty commands over valid/ready and walks the registered
// duty_cycle toward the latched target by STEP counts every STEP_CLKS clocks.
// estop forces duty to zero at once and refuses commands until released.
module duty_ramp #(
    parameter int CLOCK     = 50000000,
    parameter int WIDTH     = 8,
    parameter int STEP_CLKS = 50000,
    parameter int STEP      = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] target,
    input  logic             target_valid,
    output logic             target_ready,
    input  logic             estop,
    output logic [WIDTH-1:0] duty_cycle,
    output logic             at_target,
    output logic             busy
);

    localparam int CNT_W = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH:0]   STEP_W   = (WIDTH + 1)'(STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] duty_r, duty_s;
    logic [WIDTH-1:0] tgt_r, tgt_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             xfer_s;
    logic             tick_s;
    logic [WIDTH-1:0] stepped_s;

    // One step from cur toward goal, clamped at goal; the extra top bit keeps
    // the sums clear of wrap-around at either end of the range.
    function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                     input logic [WIDTH-1:0] goal);
        logic [WIDTH:0] cur_w;
        logic [WIDTH:0] goal_w;
        logic [WIDTH:0] up_w;
        cur_w = {1'b0, cur};
        goal_w = {1'b0, goal};
        up_w = cur_w + STEP_W;
        if (cur_w < goal_w) begin
            if (up_w >= goal_w) begin
                step_toward = goal;
            end else begin
                step_toward = up_w[WIDTH-1:0];
            end
        end else if (cur_w > goal_w) begin
            if (cur_w <= (goal_w + STEP_W)) begin
                step_toward = goal;
            end else begin
                step_toward = cur - STEP_W[WIDTH-1:0];
            end
        end else begin
            step_toward = cur;
        end
    endfunction

    // Output decode straight from registered state.
    assign target_ready = (state_r != STOP);
    assign busy         = (state_r == RAMP);
    assign at_target    = (duty_r == tgt_r) && (state_r != STOP);
    assign duty_cycle   = duty_r;

    assign xfer_s    = target_valid && (state_r != STOP);
    assign tick_s    = (cnt_r == CNT_LAST);
    assign stepped_s = step_toward(duty_r, tgt_r);

    // Next-state, next-duty, latched target and tick counter.
    always_comb begin
        state_s = state_r;
        duty_s  = duty_r;
        tgt_s   = tgt_r;
        cnt_s   = cnt_r;
        if (estop) begin
            state_s = STOP;
            duty_s  = {WIDTH{1'b0}};
            tgt_s   = {WIDTH{1'b0}};
            cnt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (xfer_s) begin
                        tgt_s = target;
                        if (target != duty_r) begin
                            state_s = RAMP;
                            cnt_s   = {CNT_W{1'b0}};
                        end else begin
                            state_s = IDLE;
                        end
                    end else if (duty_r != tgt_r) begin
                        // A step that landed on the old target while a new one
                        // was being latched leaves us here with work to do.
                        state_s = RAMP;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_s = IDLE;
                    end
                end
                RAMP: begin
                    if (xfer_s) begin
                        tgt_s = target;
                    end else begin
                        tgt_s = tgt_r;
                    end
                    if (tick_s) begin
                        cnt_s  = {CNT_W{1'b0}};
                        duty_s = stepped_s;
                        if (stepped_s == tgt_r) begin
                            state_s = IDLE;
                        end else begin
                            state_s = RAMP;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                STOP: begin
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                    duty_s  = {WIDTH{1'b0}};
                    tgt_s   = {WIDTH{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State registers with synchronous clear taking priority over everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= IDLE;
            duty_r  <= {WIDTH{1'b0}};
            tgt_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            duty_r  <= duty_s;
            tgt_r   <= tgt_s;
            cnt_r   <= cnt_s;
        end
    end

endmodule
